countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//   Loadable down-counter, the counterpart to the team's 8-bit up-counter.
//   - Accepts a start value over a valid/ready load port.
//   - Decrements once per prescaled tick.
//   - Pulses `expired` when the count reaches zero.
//   - Sits beside the up-counter in the top level as the timeout/interval source.
// PARAMETERS
//   WIDTH     8  count and load width in bits
//   PRESCALE  1  clk cycles per decrement tick; legal range 1..255
// PORTS
//   clk         in   1      clock; all logic on posedge
//   rst         in   1      synchronous reset, active-high
//   load_valid  in   1      load request
//   load_ready  out  1      load accept; high only in IDLE
//   load_value  in   WIDTH  start value, sampled on accept
//   pause       in   1      level; freezes count and prescaler while high
//   abort       in   1      level; returns to IDLE with no expired pulse
//   count       out  WIDTH  current count, registered
//   busy        out  1      high in RUN or PAUSE
//   expired     out  1      one-cycle pulse, registered
// BEHAVIOUR
//   Reset (rst high at posedge):
//   - count=0, busy=0, expired=0, load_ready=1, state IDLE, prescaler=0.
//   - rst overrides every other input, including mid-RUN and mid-PAUSE.
//   States: IDLE, RUN, PAUSE. busy = (state != IDLE). load_ready = (state == IDLE).
//   Load accept = load_valid & load_ready.
//   - load_value != 0: next cycle count=load_value, state RUN, prescaler=0.
//   - load_value == 0: count stays 0, state stays IDLE, expired pulses next cycle.
//   RUN:
//   - Tick when prescaler reaches PRESCALE-1; prescaler then returns to 0.
//   - First decrement lands exactly PRESCALE cycles after count is loaded.
//   - Tick with count > 1: count decrements by 1.
//   - Tick with count == 1: count=0, expired=1 and state IDLE, all in the same cycle.
//   - count never wraps below 0.
//   pause:
//   - pause high in RUN: next cycle is PAUSE; count and prescaler hold.
//   - A tick due in the same cycle as pause is suppressed.
//   - pause low in PAUSE: next cycle is RUN; prescaler resumes from its held value.
//   abort:
//   - abort high in RUN or PAUSE: next cycle count=0, state IDLE, no expired pulse.
//   - abort is ignored in IDLE.
//   Priority, highest first: rst > abort > pause > tick.
//   - abort and a count==1 tick in the same cycle: abort wins, no expired pulse.
//   Inputs are synchronous to clk; no CDC inside.
// CONFIGURATION
//   Macro COUNTDOWN_AUTO_RELOAD_EN.
//   - Defined: reload register (WIDTH bits) captures load_value on every accept.
//     Reset value of the reload register is 0.
//     On the count==1 tick: expired pulses, count=reload value, state stays RUN,
//     prescaler restarts at 0.
//     The timer free-runs until abort or rst. pause and abort behave as above.
//     load_value==0 behaves the same as without the macro (IDLE plus expired pulse).
//   - Undefined: no reload register; expiry always returns to IDLE with count=0.
// STRUCTURE
//   Package countdown_pkg:
//   - state enum (IDLE, RUN, PAUSE)
//   - COUNT_W default constant = 8
//   - PRESCALE_MAX = 255
//   Sub-module tick_prescaler:
//   - inputs: clk, rst, run, clear
//   - output: tick, a one-cycle pulse every PRESCALE run-cycles
//   - counter holds while run is low; clear forces it to 0
//   - PRESCALE=1 yields tick on every run cycle
//   Top level holds the FSM, count register, expired register and optional reload register.
// TESTING
//   1 Reset with outputs dirty -> count=0, busy=0, expired=0, load_ready=1.
//   2 PRESCALE=1, load 3 -> count 3,2,1,0 on successive cycles;
//     expired high only in the cycle count=0; busy drops that cycle.
//   3 PRESCALE=4, load 2, pause high for 5 cycles after the first decrement
//     -> count holds at 1 for 5 cycles; expiry arrives 8+5 cycles after load.
//   4 Load 0 -> expired pulses once next cycle; busy never rises.
//     load_valid while busy -> not accepted, count unaffected.
//   5 Abort at count=1 in the same cycle as the tick -> count=0, IDLE, expired stays 0.
//     rst mid-RUN at count=5 -> all reset values next cycle.
//   6 COUNTDOWN_AUTO_RELOAD_EN, PRESCALE=1, load 2 -> count 2,1,2,1,...;
//     expired every 2 cycles; abort -> IDLE, count=0.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN (see countdown_timer.sv).
package countdown_pkg;

  // Default count/load width in bits.
  localparam int COUNT_W      = 8;
  // Largest legal prescale ratio; also sizes the prescaler counter.
  localparam int PRESCALE_MAX = 255;
  localparam int PRESC_W      = $clog2(PRESCALE_MAX + 1);

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Load/control/status bundle of the countdown timer.
// master = the block driving loads and controls, slave = the timer itself.
interface countdown_timer_if
  import countdown_pkg::*;
#(
  parameter int WIDTH = COUNT_W
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             expired;

  modport master (
    output load_valid, load_value, pause, abort,
    input  load_ready, count, busy, expired
  );

  modport slave (
    input  load_valid, load_value, pause, abort,
    output load_ready, count, busy, expired
  );

endinterface

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides run-cycles by PRESCALE and emits a one-cycle tick on the last
// cycle of each period. The counter holds while run is low so a paused
// timer resumes mid-period; clear restarts the period.
module tick_prescaler
  import countdown_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  // Out-of-range ratios are clamped to the legal 1..PRESCALE_MAX window.
  localparam int P_EFF = (PRESCALE < 1) ? 1 :
                         ((PRESCALE > PRESCALE_MAX) ? PRESCALE_MAX : PRESCALE);
  localparam logic [PRESC_W-1:0] P_LAST = PRESC_W'(P_EFF - 1);

  logic [PRESC_W-1:0] r_cnt;
  logic               w_at_last;

  assign w_at_last = (r_cnt == P_LAST);
  assign tick      = run & w_at_last;

  // Period counter: clear/tick restart it, run advances it, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {PRESC_W{1'b0}};
    end else if (clear) begin
      r_cnt <= {PRESC_W{1'b0}};
    end else if (tick) begin
      r_cnt <= {PRESC_W{1'b0}};
    end else if (run) begin
      r_cnt <= r_cnt + {{(PRESC_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaled decrement, pause/abort control and
// a registered one-cycle expiry pulse.
// Optional macro COUNTDOWN_AUTO_RELOAD_EN: expiry reloads the last accepted
// start value and keeps running instead of returning to IDLE.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH    = COUNT_W,
  parameter int PRESCALE = 1
) (
  input logic               clk,
  input logic               rst,
  countdown_timer_if.slave  bus
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_expired;
  logic             w_expired_nxt;
  logic             w_accept;
  logic             w_run;
  logic             w_tick;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;
`endif

  assign w_accept = bus.load_valid & (r_state == IDLE);
  // The prescaler advances in any busy state unless frozen or aborted, so
  // leaving PAUSE costs no extra cycle.
  assign w_run    = (r_state != IDLE) & ~bus.abort & ~bus.pause;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_presc (
    .clk   (clk),
    .rst   (rst),
    .run   (w_run),
    .clear (w_accept),
    .tick  (w_tick)
  );

  // Next-state, next-count and expiry decision; priority abort > pause > tick.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_expired_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.load_valid) begin
          if (bus.load_value != ZERO) begin
            w_count_nxt = bus.load_value;
            w_state_nxt = RUN;
          end else begin
            w_expired_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN, PAUSE: begin
        if (bus.abort) begin
          w_count_nxt = ZERO;
          w_state_nxt = IDLE;
        end else if (bus.pause) begin
          w_state_nxt = PAUSE;
        end else begin
          w_state_nxt = RUN;
          if (w_tick) begin
            if (r_count > ONE) begin
              w_count_nxt = r_count - ONE;
            end else begin
              // Final tick (count==1); a zero count here would also land
              // here, so the counter can never wrap.
              w_expired_nxt = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              w_count_nxt   = r_reload;
              w_state_nxt   = RUN;
`else
              w_count_nxt   = ZERO;
              w_state_nxt   = IDLE;
`endif
            end
          end else begin
            w_count_nxt = r_count;
          end
        end
      end
      default: begin
        w_count_nxt = ZERO;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, count and expiry pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_count   <= ZERO;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_expired <= w_expired_nxt;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // Reload value: captured on every accepted load, including zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reload <= ZERO;
    end else if (w_accept) begin
      r_reload <= bus.load_value;
    end else begin
      r_reload <= r_reload;
    end
  end
`endif

  assign bus.count      = r_count;
  assign bus.expired    = r_expired;
  assign bus.busy       = (r_state != IDLE);
  assign bus.load_ready = (r_state == IDLE);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: two timers (PRESCALE 1 and 4) share stimulus and are
// compared every cycle against a cycle-count reference model; a vector table
// and hand sequences pin down the documented corner cases.
module tb_countdown_timer;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  countdown_timer_if #(.WIDTH(8)) bus1 ();
  countdown_timer_if #(.WIDTH(8)) bus4 ();

  countdown_timer #(.WIDTH(8), .PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  countdown_timer #(.WIDTH(8), .PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, index 0 -> PRESCALE 1, index 1 -> PRESCALE 4.
  int m_count  [2] = '{0, 0};
  int m_busy   [2] = '{0, 0};
  int m_exp    [2] = '{0, 0};
  int m_runcyc [2] = '{0, 0};
  int m_reload [2] = '{0, 0};
  int m_p      [2] = '{1, 4};

  typedef struct {
    bit   r;
    bit   lv;
    int   val;
    bit   pz;
    bit   ab;
    int   e_count;
    bit   e_busy;
    bit   e_exp;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(bit r, bit lv, int val, bit pz, bit ab,
                              int ec, bit eb, bit ee);
    vec_t v;
    v.r = r; v.lv = lv; v.val = val; v.pz = pz; v.ab = ab;
    v.e_count = ec; v.e_busy = eb; v.e_exp = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock of the specified behaviour, counting elapsed run-cycles since
  // the last load/expiry; a decrement falls on every PRESCALE-th one.
  task automatic model_step(input int k, input bit r, input bit lv, input int val,
                            input bit pz, input bit ab);
    m_exp[k] = 0;
    if (r) begin
      m_count[k] = 0; m_busy[k] = 0; m_runcyc[k] = 0; m_reload[k] = 0;
    end else if (m_busy[k] == 0) begin
      if (lv) begin
        m_reload[k] = val;
        if (val == 0) m_exp[k] = 1;
        else begin
          m_count[k] = val; m_busy[k] = 1; m_runcyc[k] = 0;
        end
      end
    end else if (ab) begin
      m_busy[k] = 0; m_count[k] = 0;
    end else if (!pz) begin
      m_runcyc[k]++;
      if (m_runcyc[k] % m_p[k] == 0) begin
        if (m_count[k] > 1) m_count[k]--;
        else begin
          m_exp[k] = 1;
          if (AR) m_count[k] = m_reload[k];
          else begin
            m_count[k] = 0; m_busy[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit lv, input int val, input bit pz, input bit ab);
    rst = r;
    bus1.load_valid = lv; bus1.load_value = 8'(val); bus1.pause = pz; bus1.abort = ab;
    bus4.load_valid = lv; bus4.load_value = 8'(val); bus4.pause = pz; bus4.abort = ab;
    @(posedge clk);
    model_step(0, r, lv, val, pz, ab);
    model_step(1, r, lv, val, pz, ab);
    #1;
    chk("p1_count",   32'(bus1.count),      32'(m_count[0]));
    chk("p1_busy",    32'(bus1.busy),       32'(m_busy[0]));
    chk("p1_expired", 32'(bus1.expired),    32'(m_exp[0]));
    chk("p1_ready",   32'(bus1.load_ready), 32'(m_busy[0] == 0));
    chk("p4_count",   32'(bus4.count),      32'(m_count[1]));
    chk("p4_busy",    32'(bus4.busy),       32'(m_busy[1]));
    chk("p4_expired", 32'(bus4.expired),    32'(m_exp[1]));
    chk("p4_ready",   32'(bus4.load_ready), 32'(m_busy[1] == 0));
  endtask

  initial begin : main
    int lat;
    // Vector table for the PRESCALE=1 timer: inputs -> count, busy, expired.
    tbl[0]  = mk(1, 1, 9, 1, 1, 0, 0, 0);                 // reset beats all inputs
    tbl[1]  = mk(0, 1, 3, 0, 0, 3, 1, 0);                 // load 3
    tbl[2]  = mk(0, 0, 0, 0, 0, 2, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 1, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, AR ? 3 : 0, AR, 1);       // expiry
    tbl[5]  = mk(0, 0, 0, 0, 1, 0, 0, 0);                 // abort (ignored if idle)
    tbl[6]  = mk(0, 1, 0, 0, 0, 0, 0, 1);                 // load 0 -> pulse only
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 5, 0, 0, 5, 1, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0);                 // rst mid-RUN at 5
    tbl[10] = mk(0, 1, 6, 0, 0, 6, 1, 0);
    tbl[11] = mk(0, 1, 7, 0, 0, 5, 1, 0);                 // load while busy ignored
    tbl[12] = mk(0, 0, 0, 1, 0, 5, 1, 0);                 // pause freezes
    tbl[13] = mk(0, 0, 0, 1, 0, 5, 1, 0);
    tbl[14] = mk(1, 0, 0, 1, 0, 0, 0, 0);                 // rst mid-PAUSE
    tbl[15] = mk(0, 1, 2, 0, 0, 2, 1, 0);
    tbl[16] = mk(0, 0, 0, 1, 0, 2, 1, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 1, 1, 0);                 // resume from PAUSE
    tbl[18] = mk(0, 0, 0, 0, 1, 0, 0, 0);                 // abort beats final tick
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0);

    step(1, 0, 0, 0, 0);
    step(0, 1, 9, 0, 0);                                  // make outputs dirty
    chk("dirty_count", 32'(bus1.count), 32'd9);
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].r, tbl[i].lv, tbl[i].val, tbl[i].pz, tbl[i].ab);
      chk($sformatf("vec%0d_count", i),   32'(bus1.count),   32'(tbl[i].e_count));
      chk($sformatf("vec%0d_busy", i),    32'(bus1.busy),    32'(tbl[i].e_busy));
      chk($sformatf("vec%0d_expired", i), 32'(bus1.expired), 32'(tbl[i].e_exp));
    end

    // PRESCALE=4, load 2, pause 5 cycles after the first decrement.
    step(1, 0, 0, 0, 0);
    step(0, 1, 2, 0, 0);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step(0, 0, 0, (i >= 5 && i <= 9), 0);
      if (i >= 4 && i <= 9) chk("p4_hold_count", 32'(bus4.count), 32'd1);
      if (bus4.expired === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("p4_expiry_latency", 32'(lat), 32'd13);
    step(0, 0, 0, 0, 1);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Free-running reload with PRESCALE=1: 2,1,2,1,... then abort.
    step(1, 0, 0, 0, 0);
    step(0, 1, 2, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0);
      chk("ar_count",   32'(bus1.count),   (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("ar_expired", 32'(bus1.expired), (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    step(0, 0, 0, 0, 1);
    chk("ar_abort_count", 32'(bus1.count), 32'd0);
    chk("ar_abort_busy",  32'(bus1.busy),  32'd0);
`endif

    // Randomized stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 3) == 0,
           ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12)),
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 24) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
